data_pack_fifo_6to8: RTL and testbench



---
 rtl/data_convert_pkg.sv | 18 +
 rtl/sync_byte_fifo.sv | 68 ++++++
 rtl/data_pack_fifo_6to8.sv | 104 ++++++++++
 tb/tb_data_pack_fifo_6to8.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_convert_pkg.sv
// Shared widths, packer phase encoding and default FIFO sizing for the
// 6-bit <-> 8-bit data-convert blocks.
package data_convert_pkg;

    localparam int unsigned WORD_W         = 6;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned DEFAULT_DEPTH  = 16;
    localparam int unsigned DEFAULT_ADDR_W = 4;

    // Encodes how many bits are pending in the packer hold register.
    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH6 = 2'd1,
        PH4 = 2'd2,
        PH2 = 2'd3
    } phase_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with a registered head output (1-cycle read latency)
// and registered empty/full flags.
module sync_byte_fifo
    import data_convert_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] data_out,
    output logic              empty,
    output logic              full
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic              do_push;
    logic              do_pop;

    // A pop against an empty FIFO (including one being written this cycle) is dropped.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_next = count;
        unique case ({do_push, do_pop})
            2'b10:   count_next = count + (ADDR_W+1)'(1);
            2'b01:   count_next = count - (ADDR_W+1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_pop) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + ADDR_W'(1);
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == (ADDR_W+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/data_pack_fifo_6to8.sv
// Packs a 6-bit word stream MSB-first into bytes (4 words -> 3 bytes) and
// buffers the bytes in a FIFO drained by the downstream consumer.
module data_pack_fifo_6to8
    import data_convert_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] data_in,
    input  logic              flush,
    input  logic              read_en,
    output logic [BYTE_W-1:0] data_out,
    output logic              empty,
    output logic              full
);

    phase_t            phase;
    phase_t            phase_next;
    logic [WORD_W-1:0] hold;
    logic [WORD_W-1:0] hold_next;
    logic              push;
    logic [BYTE_W-1:0] push_data;
    logic              accept;
    logic              flush_go;

    // A PH0 word never produces a byte, so it can be taken even when full.
    assign in_ready = (phase == PH0) || !full;
    assign accept   = in_valid && in_ready;
    assign flush_go = flush && !in_valid && !full && (phase != PH0);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= PH0;
            hold  <= '0;
        end else begin
            phase <= phase_next;
            hold  <= hold_next;
        end
    end

    always_comb begin
        phase_next = phase;
        hold_next  = hold;
        push       = 1'b0;
        push_data  = '0;
        if (accept) begin
            unique case (phase)
                PH0: begin
                    hold_next  = data_in;
                    phase_next = PH6;
                end
                PH6: begin
                    push       = 1'b1;
                    push_data  = {hold, data_in[5:4]};
                    hold_next  = {data_in[3:0], 2'b00};
                    phase_next = PH4;
                end
                PH4: begin
                    push       = 1'b1;
                    push_data  = {hold[5:2], data_in[5:2]};
                    hold_next  = {data_in[1:0], 4'b0000};
                    phase_next = PH2;
                end
                PH2: begin
                    push       = 1'b1;
                    push_data  = {hold[5:4], data_in};
                    hold_next  = '0;
                    phase_next = PH0;
                end
                default: phase_next = PH0;
            endcase
        end else if (flush_go) begin
            // Zero-pad whatever partial bits remain into one final byte.
            push       = 1'b1;
            hold_next  = '0;
            phase_next = PH0;
            unique case (phase)
                PH6:     push_data = {hold, 2'b00};
                PH4:     push_data = {hold[5:2], 4'b0000};
                PH2:     push_data = {hold[5:4], 6'b000000};
                default: push      = 1'b0;
            endcase
        end
    end

    sync_byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (read_en),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full)
    );

endmodule

// File: tb/tb_data_pack_fifo_6to8.sv
// Directed bench for data_pack_fifo_6to8: a bit-accumulator model predicts
// every cycle, plus hand-computed byte values for each scenario.
module tb_data_pack_fifo_6to8;
    import data_convert_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] data_in;
    logic       flush;
    logic       read_en;
    logic [7:0] data_out;
    logic       empty;
    logic       full;

    data_pack_fifo_6to8 #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .flush    (flush),
        .read_en  (read_en),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          mbits;
    logic [13:0] macc;
    int          mcount;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  last_out;
    bit          last_acc;
    bit          last_push;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_phase(input int bits);
        case (bits)
            6:       return 32'd1;
            4:       return 32'd2;
            2:       return 32'd3;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: predict from current inputs, advance, then compare outputs.
    task automatic tick();
        bit         exp_ready;
        bit         acc;
        bit         popm;
        bit         pushm;
        logic [7:0] pb;
        logic [7:0] pv;
        if (reset) begin
            @(posedge clk);
            #1;
            mbits = 0; macc = '0; mcount = 0; exp_q.delete();
            last_out = 8'h00; last_acc = 1'b0; last_push = 1'b0;
            chk("rst_empty", 32'(empty), 32'd1);
            chk("rst_full", 32'(full), 32'd0);
            chk("rst_data_out", 32'(data_out), 32'h00);
            chk("rst_phase", 32'(dut.phase), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            return;
        end
        exp_ready = (mbits == 0) || (mcount != int'(DEPTH));
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        acc   = in_valid && exp_ready;
        popm  = read_en && (mcount != 0);
        pushm = 1'b0;
        pb    = 8'h00;
        pv    = 8'h00;
        if (acc) begin
            macc  = (macc << 6) | 14'(data_in);
            mbits = mbits + 6;
            if (mbits >= 8) begin
                pb    = 8'(macc >> (mbits - 8));
                mbits = mbits - 8;
                macc  = macc & ((14'd1 << mbits) - 14'd1);
                pushm = 1'b1;
            end
        end else if (flush && !in_valid && mbits != 0 && mcount != int'(DEPTH)) begin
            pb    = 8'(macc << (8 - mbits));
            pushm = 1'b1;
            mbits = 0;
            macc  = '0;
        end
        if (popm) pv = exp_q.pop_front();
        if (pushm) exp_q.push_back(pb);
        mcount = mcount + (pushm ? 1 : 0) - (popm ? 1 : 0);
        @(posedge clk);
        #1;
        if (popm) begin
            chk("pop_data", 32'(data_out), 32'(pv));
            got_q.push_back(data_out);
            last_out = pv;
        end else begin
            chk("data_hold", 32'(data_out), 32'(last_out));
        end
        chk("empty", 32'(empty), 32'(mcount == 0));
        chk("full", 32'(full), 32'(mcount == int'(DEPTH)));
        chk("phase", 32'(dut.phase), exp_phase(mbits));
        last_acc  = acc;
        last_push = pushm;
    endtask

    // Present a word and clock until it is accepted (bounded).
    task automatic send_word(input logic [5:0] w);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        data_in  = w;
        for (int k = 0; k < 100 && !done; k++) begin
            tick();
            done = last_acc;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; data_in = '0; flush = 1'b0; read_en = 1'b0;
        mbits = 0; macc = '0; mcount = 0; last_out = 8'h00; last_acc = 1'b0; last_push = 1'b0;
        tick();
        do_reset();

        // Basic packing with continuous draining.
        got_q.delete();
        read_en = 1'b1;
        send_word(6'h3F); send_word(6'h00); send_word(6'h3F); send_word(6'h00);
        idle(4);
        chk("t1_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("t1_b0", 32'(got_q[0]), 32'hFC);
            chk("t1_b1", 32'(got_q[1]), 32'h0F);
            chk("t1_b2", 32'(got_q[2]), 32'hC0);
        end
        chk("t1_phase", 32'(dut.phase), 32'd0);
        chk("t1_empty", 32'(empty), 32'd1);

        got_q.delete();
        send_word(6'h01);
        chk("t2_no_push_first", 32'(last_push), 32'd0);
        chk("t2_empty_first", 32'(empty), 32'd1);
        send_word(6'h02); send_word(6'h03); send_word(6'h04);
        idle(4);
        chk("t2_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("t2_b0", 32'(got_q[0]), 32'h04);
            chk("t2_b1", 32'(got_q[1]), 32'h20);
            chk("t2_b2", 32'(got_q[2]), 32'hC4);
        end

        // Flush of a partial word, then a no-op flush in PH0.
        got_q.delete();
        read_en = 1'b0;
        send_word(6'h2A);
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        chk("t3_flush_push", 32'(last_push), 32'd1);
        chk("t3_phase", 32'(dut.phase), 32'd0);
        tick();
        chk("t3_second_flush", 32'(last_push), 32'd0);
        flush   = 1'b0;
        read_en = 1'b1;
        idle(3);
        chk("t3_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) chk("t3_b0", 32'(got_q[0]), 32'hA8);

        // Fill to full, stall the input, then drain across the pointer wrap.
        got_q.delete();
        read_en = 1'b0;
        for (int i = 0; i < 22; i++) send_word(6'(i));
        chk("t4_full", 32'(full), 32'd1);
        chk("t4_phase_full", 32'(dut.phase), 32'd2);
        in_valid = 1'b1;
        data_in  = 6'd22;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_stall", 32'(last_acc), 32'd0);
            chk("t4_in_ready_low", 32'(in_ready), 32'd0);
        end
        read_en = 1'b1;
        for (int i = 22; i < 30; i++) send_word(6'(i));
        in_valid = 1'b0;
        flush    = 1'b1;
        for (int k = 0; k < 50 && mbits != 0; k++) tick();
        chk("t4_flush_done", 32'(mbits), 32'd0);
        flush = 1'b0;
        idle(30);
        chk("t4_count", 32'(got_q.size()), 32'd23);
        if (got_q.size() == 23) begin
            chk("t4_b0", 32'(got_q[0]), 32'h00);
            chk("t4_b1", 32'(got_q[1]), 32'h10);
            chk("t4_b2", 32'(got_q[2]), 32'h83);
            chk("t4_b21", 32'(got_q[21]), 32'h71);
            chk("t4_b22", 32'(got_q[22]), 32'hD0);
        end

        // Reads while empty are ignored; push-with-read on empty pops next cycle.
        read_en = 1'b1;
        idle(5);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_hold", 32'(data_out), 32'hD0);
        send_word(6'h3F);
        send_word(6'h3F);
        in_valid = 1'b0;
        chk("t5_push", 32'(last_push), 32'd1);
        chk("t5_not_yet", 32'(data_out), 32'hD0);
        chk("t5_nonempty", 32'(empty), 32'd0);
        tick();
        chk("t5_appears", 32'(data_out), 32'hFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle(3);
        chk("t5_flush_byte", 32'(data_out), 32'hF0);

        // Reset mid-stream with 5 bytes queued in PH4.
        read_en = 1'b0;
        send_word(6'h3F); send_word(6'h00);
        in_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
        send_word(6'h3F); send_word(6'h00);
        in_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
        send_word(6'h3F); send_word(6'h00);
        in_valid = 1'b0;
        chk("t6_queued", 32'(mcount), 32'd5);
        chk("t6_phase_pre", 32'(dut.phase), 32'd2);
        do_reset();
        got_q.delete();
        read_en = 1'b1;
        send_word(6'h3F); send_word(6'h00); send_word(6'h3F); send_word(6'h00);
        idle(4);
        chk("t6_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("t6_b0", 32'(got_q[0]), 32'hFC);
            chk("t6_b1", 32'(got_q[1]), 32'h0F);
            chk("t6_b2", 32'(got_q[2]), 32'hC0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
